// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - multi-channel switch/button debouncer with edge strobes
//
// Purpose:
//    Conditions WIDTH raw switch/button pins. Each channel is synchronised
//    to clk through two flops. A new value is accepted onto level_out only
//    after it has been seen for DEBOUNCE_CYCLES consecutive synchronised
//    samples. Every accepted change raises a registered single-cycle rise or
//    fall strobe, which appears in the same cycle as the new level.
//
// Ports:
//    clk         system clock, rising edge
//    rst_n       asynchronous active-low reset
//    raw_in      [WIDTH] asynchronous pins, one per channel
//    level_out   [WIDTH] debounced level
//    rise_pulse  [WIDTH] one-cycle strobe, level_out went 0->1
//    fall_pulse  [WIDTH] one-cycle strobe, level_out went 1->0
//    any_change  OR of every rise_pulse and fall_pulse bit

module switch_debouncer #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_CONFIRM = 1'b1
   } state_t;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic          s1;
      logic          s2;
      state_t        state_q;
      state_t        state_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          level_q;
      logic          level_d;
      logic          rise_q;
      logic          rise_d;
      logic          fall_q;
      logic          fall_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            s1      <= raw_in[i];
            s2      <= s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      // The first differing sample already counts as one, so the value is
      // accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         level_d = level_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         case (state_q)
            ST_STABLE: begin
               if (s2 != level_q) begin
                  state_d = ST_CONFIRM;
                  cnt_d   = CNT_ONE;
               end
            end
            ST_CONFIRM: begin
               if (s2 == level_q) begin
                  // Single-bit input: any change here is a bounce back.
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
                  level_d = s2;
                  rise_d  = s2;
                  fall_d  = ~s2;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      assign level_out[i]  = level_q;
      assign rise_pulse[i] = rise_q;
      assign fall_pulse[i] = fall_q;
   end

   // Built from the registered strobes, so it lines up with them exactly.
   assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
//
// Purpose:
//    Directed scenarios plus randomized hold-length stimulus, compared every
//    cycle against a behavioural model: a pin value is accepted once the
//    synchronised pin has differed from the accepted level for D samples.
//
// Ports: none (top-level bench).

module tb_switch_debouncer;

   localparam int W = 2;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] raw_in;
   logic [W-1:0] level_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic         any_change;

   int checks = 0;
   int errors = 0;

   switch_debouncer #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_change (any_change)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   // Behavioural model: pin samples enter a two-deep delay queue; the value
   // leaving it is compared with the accepted level and a run length of
   // consecutive disagreeing samples decides acceptance.
   logic [W-1:0] m_delay [$];
   logic [W-1:0] m_level;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   int           m_run [W];
   int           rise_seen [W];
   int           fall_seen [W];

   task automatic model_reset();
      m_delay = {};
      m_delay.push_back('0);
      m_delay.push_back('0);
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
   endtask

   task automatic model_edge(input logic [W-1:0] r);
      logic [W-1:0] v;
      v = m_delay.pop_front();
      m_delay.push_back(r);
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < W; c++) begin
         if (v[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == D) begin
               m_level[c] = v[c];
               if (v[c]) m_rise[c] = 1'b1;
               else      m_fall[c] = 1'b1;
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
   endtask

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic any_exp;
      any_exp = |(m_rise | m_fall);
      check_val({tag, " level_out"}, level_out, m_level);
      check_val({tag, " rise_pulse"}, rise_pulse, m_rise);
      check_val({tag, " fall_pulse"}, fall_pulse, m_fall);
      checks++;
      assert (any_change === any_exp) else begin
         errors++;
         $error("FAIL %s any_change: got %b expected %b", tag, any_change, any_exp);
      end
   endtask

   task automatic clear_seen();
      for (int c = 0; c < W; c++) begin
         rise_seen[c] = 0;
         fall_seen[c] = 0;
      end
   endtask

   task automatic step(input logic [W-1:0] r, input string tag);
      raw_in = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_model(tag);
      for (int c = 0; c < W; c++) begin
         rise_seen[c] += int'(rise_pulse[c]);
         fall_seen[c] += int'(fall_pulse[c]);
      end
   endtask

   // Asserts reset between edges, holds it over n edges, releases between edges.
   task automatic pulse_reset(input int n, input logic [W-1:0] r, input string tag);
      raw_in = r;
      rst_n  = 1'b0;
      model_reset();
      #1;
      check_model({tag, " in reset"});
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         check_model({tag, " held"});
      end
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int first_hi;
      rst_n  = 1'b0;
      raw_in = 2'b11;
      clear_seen();
      model_reset();

      // 1: reset with pins high, then release with pins held high
      pulse_reset(3, 2'b11, "t1");
      for (int k = 1; k <= 8; k++) begin
         step(2'b11, "t1");
         if (k == 5) check_val("t1 level before edge 6", level_out, 2'b00);
         if (k == 6) begin
            check_val("t1 level at edge 6", level_out, 2'b11);
            check_val("t1 rise at edge 6", rise_pulse, 2'b11);
            check_val("t1 any_change at edge 6", {1'b0, any_change}, 2'b01);
         end
         if (k == 7) check_val("t1 rise cleared", rise_pulse, 2'b00);
      end
      for (int k = 0; k < 8; k++) step(2'b00, "t1 return");

      // 2: clean press and release on ch0
      clear_seen();
      for (int k = 1; k <= 8; k++) begin
         step(2'b01, "t2 press");
         if (k == 6) check_val("t2 rise at edge 6", rise_pulse, 2'b01);
      end
      for (int k = 1; k <= 8; k++) begin
         step(2'b00, "t2 release");
         if (k == 6) check_val("t2 fall at edge 6", fall_pulse, 2'b01);
      end
      check_int("t2 rise count ch0", rise_seen[0], 1);
      check_int("t2 fall count ch0", fall_seen[0], 1);

      // 3: bounce on ch1, then settle high
      clear_seen();
      first_hi = -1;
      for (int k = 0; k < 14; k++) begin
         logic b;
         b = (k < 5) ? logic'(k % 2) : 1'b1;
         step({b, 1'b0}, "t3");
         if (level_out[1] && first_hi < 0) first_hi = k;
      end
      check_int("t3 settle edge index", first_hi, 10);
      check_int("t3 rise count ch1", rise_seen[1], 1);
      for (int k = 0; k < 8; k++) step(2'b00, "t3 return");

      // 4: glitch one sample short of acceptance, then one just long enough
      clear_seen();
      for (int k = 0; k < D - 1; k++) step(2'b01, "t4 short");
      for (int k = 0; k < 8; k++) step(2'b00, "t4 short low");
      check_int("t4 short rise count", rise_seen[0], 0);
      check_int("t4 short fall count", fall_seen[0], 0);
      for (int k = 0; k < D; k++) step(2'b01, "t4 long");
      for (int k = 0; k < 10; k++) step(2'b00, "t4 long low");
      check_int("t4 long rise count", rise_seen[0], 1);
      check_int("t4 long fall count", fall_seen[0], 1);

      // 5: independent events two cycles apart
      clear_seen();
      for (int k = 1; k <= 12; k++) begin
         step((k < 3) ? 2'b01 : 2'b11, "t5");
         if (k == 6) check_val("t5 rise at edge 6", rise_pulse, 2'b01);
         if (k == 8) check_val("t5 rise at edge 8", rise_pulse, 2'b10);
      end
      check_int("t5 rise count ch0", rise_seen[0], 1);
      check_int("t5 rise count ch1", rise_seen[1], 1);
      for (int k = 0; k < 8; k++) step(2'b00, "t5 return");

      // 6: reset lands mid-confirm, acceptance restarts after release
      clear_seen();
      for (int k = 0; k < 3; k++) step(2'b01, "t6 pre");
      pulse_reset(1, 2'b01, "t6");
      for (int k = 1; k <= 8; k++) begin
         step(2'b01, "t6 post");
         if (k == 5) check_val("t6 level before edge 6", level_out, 2'b00);
         if (k == 6) check_val("t6 level at edge 6", level_out, 2'b01);
      end
      check_int("t6 rise count ch0", rise_seen[0], 1);

      // Randomized hold lengths around the acceptance threshold
      for (int seg = 0; seg < 300; seg++) begin
         logic [W-1:0] r;
         int           len;
         r   = W'($urandom);
         len = $urandom_range(1, D + 3);
         if ($urandom_range(0, 29) == 0) pulse_reset($urandom_range(0, 2), r, "rand");
         for (int k = 0; k < len; k++) step(r, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
